// File: rtl/pipe_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_scoreboard_if                                   |
// | Description : Issue-stage handshake between decode and the         |
// |               register scoreboard (sources, destination, latency). |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface pipe_scoreboard_if #(
  parameter int AW = 5,
  parameter int LW = 3
);
  logic          iss_valid;
  logic          iss_ready;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic          iss_rs1_en;
  logic          iss_rs2_en;
  logic [AW-1:0] iss_rd;
  logic          iss_rd_we;
  logic [LW-1:0] iss_lat;

  // Decode side: presents the instruction, observes the issue permission.
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en,
           iss_rd, iss_rd_we, iss_lat,
    input  iss_ready
  );

  // Scoreboard side.
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en,
           iss_rd, iss_rd_we, iss_lat,
    output iss_ready
  );
endinterface
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_scoreboard                                      |
// | Description : Per-register write-latency countdown scoreboard with |
// |               RAW/WAW issue interlock, flush and stall counter.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pipe_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 3,
  parameter int FWD  = 1
) (
  input  wire              clk,
  input  wire              rst,
  pipe_scoreboard_if.slave iss,
  input  wire              flush,
  output logic [NREG-1:0]  busy_vec,
  output logic [31:0]      stall_cnt
);
  // Full index space reachable by an AW-bit register number.
  localparam int NIDX = 1 << AW;

  logic [NREG-1:0][LW-1:0] cnt;
  logic [NIDX-1:0][LW-1:0] cnt_ext;
  logic                    rs1_ok;
  logic                    rs2_ok;
  logic                    rd_ok;
  logic                    fire;
  logic [LW-1:0]           load_val;

  // A source is ready when unused, or its producer is done, or (with the
  // bypass) the producer writes back in the cycle this operand is consumed.
  function automatic logic src_ok(input logic en, input logic [LW-1:0] c);
    return !en || (c == '0) || ((FWD == 1) && (c == LW'(1)));
  endfunction

  // Indices at or beyond NREG read as an idle count, so they never stall
  // and never match a writable entry.
  genvar gi;
  for (gi = 0; gi < NIDX; gi++) begin : g_ext
    if (gi < NREG) begin : g_in
      assign cnt_ext[gi] = cnt[gi];
    end else begin : g_out
      assign cnt_ext[gi] = '0;
    end
  end

  // Issue interlock; reset presents an empty scoreboard regardless of
  // whatever counts are still held in the registers.
  always_comb begin
    rs1_ok        = src_ok(iss.iss_rs1_en, cnt_ext[iss.iss_rs1]);
    rs2_ok        = src_ok(iss.iss_rs2_en, cnt_ext[iss.iss_rs2]);
    rd_ok         = !iss.iss_rd_we || (cnt_ext[iss.iss_rd] == '0);
    iss.iss_ready = !flush && (rst || (rs1_ok && rs2_ok && rd_ok));
    fire          = iss.iss_valid && iss.iss_ready;
    load_val      = (iss.iss_lat == '0) ? LW'(1) : iss.iss_lat;
  end

  for (gi = 0; gi < NREG; gi++) begin : g_cnt
    if (gi == 0) begin : g_zero
      assign cnt[gi] = '0;
    end else begin : g_live
      logic [LW-1:0] cnt_q;

      // Countdown: reset/flush clear, a new write reloads, else tick down.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          cnt_q <= '0;
        end else if (fire && iss.iss_rd_we && (iss.iss_rd == AW'(gi))) begin
          cnt_q <= load_val;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - LW'(1);
        end
      end

      assign cnt[gi] = cnt_q;
    end
    assign busy_vec[gi] = !rst && (cnt[gi] != '0);
  end

  // Saturating count of cycles where decode was held back by a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (iss.iss_valid && !iss.iss_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule
`default_nettype wire

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: number of architectural registers; x0 is register 0.
REQ-002 SHALL have parameter AW, default 5: register index width; NREG <= 2^AW.
REQ-003 SHALL have parameter LW, default 3: latency field width; maximum latency 2^LW-1.
REQ-004 SHALL have parameter FWD, default 1: 1 = bypass path present, so an operand with 1 cycle remaining counts as ready.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port iss_valid  input  1  decode stage presents an instruction.
REQ-008 SHALL have port iss_ready  output  1  instruction may issue this cycle.
REQ-009 SHALL have port iss_rs1 / iss_rs2  input  AW each  source register indices.
REQ-010 SHALL have port iss_rs1_en / iss_rs2_en  input  1 each  source is actually read.
REQ-011 SHALL have port iss_rd  input  AW  destination register index.
REQ-012 SHALL have port iss_rd_we  input  1  instruction writes rd.
REQ-013 SHALL have port iss_lat  input  LW  cycles until the result is written back.
REQ-014 SHALL have port flush  input  1  squash all in-flight writes (branch/jump redirect).
REQ-015 SHALL have port busy_vec  output  NREG  bit i = register i has a pending write.
REQ-016 SHALL have port stall_cnt  output  32  saturating count of stalled cycles.

Function
REQ-017 SHALL keep one LW-bit countdown cnt[i] per register; busy_vec[i] = (cnt[i] != 0); cnt[0] is constant 0.
REQ-018 SHALL define operand ready: disabled, or index 0, or cnt==0, or (FWD==1 and cnt==1).
REQ-019 SHALL drive iss_ready combinationally = !flush and rs1 ready and rs2 ready and (!iss_rd_we or iss_rd==0 or cnt[iss_rd]==0).
REQ-020 SHALL drive iss_ready independently of iss_valid; fire = iss_valid and iss_ready.
REQ-021 SHALL, every cycle, decrement each nonzero cnt[i] by 1, never below 0.
REQ-022 SHALL, on fire with iss_rd_we and iss_rd != 0, load cnt[iss_rd] with max(iss_lat,1); this load takes priority over the decrement of that entry.
REQ-023 SHALL ignore iss_rd_we when iss_rd == 0; no entry changes.
REQ-024 SHALL ignore iss_rd values >= NREG on write and treat such sources as ready.
REQ-025 SHALL, when flush is high, clear every cnt[i] to 0 at the next edge; no issue occurs that cycle.
REQ-026 SHALL increment stall_cnt by 1 in each cycle with iss_valid=1, iss_ready=0 and flush=0; it holds at 32'hFFFFFFFF.
REQ-027 SHALL have issue-to-busy latency of 1 cycle: busy_vec reflects a fired write on the next cycle.
REQ-028 SHALL keep the stall decision, countdown decrement and new load consistent within one cycle: a source whose cnt reaches 0 (or 1 with FWD) is ready in that same cycle's evaluation.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear all cnt[i] and stall_cnt to 0; rst has priority over flush and fire.
REQ-030 SHALL, during and directly after reset, hold busy_vec = 0 and iss_ready = !flush for any sources.
REQ-031 SHALL, when rst is asserted mid-operation, discard pending counts with no retire side effects.

Verification
REQ-032 SHALL cover: after rst, issue rd=5 with lat=3 -> busy_vec[5]=1 for exactly 3 cycles, then 0.
REQ-033 SHALL cover: with FWD=1, issue rd=5 lat=3, then present rs1=5 every cycle -> iss_ready=0 for 2 cycles, 1 on the 3rd; stall_cnt=2.
REQ-034 SHALL cover: with FWD=0, the same stimulus -> iss_ready=0 for 3 cycles; stall_cnt=3.
REQ-035 SHALL cover: issue rd=0 lat=7, then read rs1=0 -> busy_vec=0 and iss_ready=1 throughout.
REQ-036 SHALL cover: rd=7 busy with cnt=4; assert flush 1 cycle -> iss_ready=0 that cycle, busy_vec=0 next cycle, stall_cnt unchanged.
REQ-037 SHALL cover: rd=3 pending, second write to rd=3 -> iss_ready=0 (WAW) until cnt[3]=0; rst mid-stall -> busy_vec=0 and stall_cnt=0 next cycle.
